cache_mem_arbiter: RTL
======================

CACHE_MEM_ARBITER -- requirements
Module: cache_mem_arbiter

Interface
REQ-001 Parameter RR_EN, default 1, meaning: 1 selects round-robin arbitration; 0 selects fixed priority with port 0 (dcache) highest.
REQ-002 clk  input  1  clock; all state changes on its rising edge.
REQ-003 rst  input  1  reset, synchronous, active-high.
REQ-004 p0_avn_req  input  avalon_req_t  dcache request: read, write, address, writedata, byte_enable.
REQ-005 p0_avn_resp  output  avalon_resp_t  dcache response: readdata, waitrequest.
REQ-006 p1_avn_req  input  avalon_req_t  icache request.
REQ-007 p1_avn_resp  output  avalon_resp_t  icache response.
REQ-008 mem_avn_req  output  avalon_req_t  merged request to the memory bus.
REQ-009 mem_avn_resp  input  avalon_resp_t  memory response; readdata has a fixed 1-cycle read latency.

Function
REQ-010 A port is requesting when its read or write is 1; it is accepted in the cycle its request is forwarded and mem_avn_resp.waitrequest=0.
REQ-011 States: IDLE (no lock), LOCK0 (port 0 owns the bus), LOCK1 (port 1 owns the bus).
REQ-012 IDLE with one requesting port: grant that port combinationally in the same cycle, with zero added latency.
REQ-013 IDLE with both ports requesting: when RR_EN=1, grant the port not granted most recently (port 0 after reset); when RR_EN=0, grant port 0.
REQ-014 IDLE, granted request not accepted (mem waitrequest=1): next state LOCKn for the granted port n.
REQ-015 IDLE, granted request accepted: stay in IDLE; the last-granted pointer updates to n.
REQ-016 LOCKn: forward only port n, regardless of the other port; when port n is accepted, go to IDLE and set the last-granted pointer to n.
REQ-017 LOCKn with port n request dropped (protocol violation): return to IDLE with no memory access issued in that cycle.
REQ-018 Granted port: mem_avn_req equals that port's request field by field; p_n waitrequest equals mem_avn_resp.waitrequest.
REQ-019 Non-granted requesting port: waitrequest=1.
REQ-020 Non-requesting port: waitrequest=0.
REQ-021 No port granted: mem read=0 and write=0; address, writedata and byte_enable follow port 0.
REQ-022 mem_avn_resp.readdata is broadcast to both ports' readdata unregistered; each master samples it only on the cycle after its own accepted read.
REQ-023 Back-to-back accepts: a new grant is allowed in the cycle after an accept, with no bubble; the prior read's readdata still returns correctly in that cycle.
REQ-024 Never assert mem read and write simultaneously; when a port drives both, forward it unchanged (the port is responsible for its encoding).

Reset
REQ-025 While rst=1 and in the cycle after it: state=IDLE and last-granted pointer=port 1, so port 0 wins the first tie.
REQ-026 During rst, mem read=0 and write=0, and both port waitrequests are 0.
REQ-027 rst asserted mid-LOCK: abandon the lock and discard any in-flight transfer; no response is guaranteed for it.

Verification
REQ-028 Memory waitrequest=0; only p1 reads 0x100 -> mem read=1 with address 0x100 in the same cycle; the next cycle p1 readdata equals the memory data.
REQ-029 p0 and p1 both read continuously, waitrequest=0, RR_EN=1 -> grants alternate p0, p1, p0, p1; each loser sees waitrequest=1.
REQ-030 p0 writes 0x200 with data 0xDEADBEEF, memory waitrequest=1 for 3 cycles; p1 requests in cycle 2 -> mem request stays p0's for 4 cycles, then p1 is granted in cycle 5.
REQ-031 RR_EN=0, both requesting continuously -> p0 is always granted; p1 waitrequest stays 1.
REQ-032 rst asserted during LOCK1 -> the next cycle is IDLE with mem read/write=0, and the first tie after reset goes to p0.
REQ-033 Alternating p0 read and p1 read accepted in consecutive cycles -> each readdata is sampled by the correct port one cycle after its own accept.

Source files
------------

// File: rtl/cache_mem_arbiter.sv
// Two-port Avalon-MM arbiter: merges the dcache (port 0) and icache (port 1)
// masters onto a single memory bus. A port keeps ownership of the bus
// while the memory stalls it, and readdata is broadcast to both masters.
//
// Handshake: a port is requesting while read or write is 1. Its request is
// accepted in the cycle it is forwarded to memory and memory waitrequest is 0.
// A master must hold its request stable while its own waitrequest is 1.
// Read data returns exactly one cycle after an accepted read.

package cache_mem_arbiter_pkg;

    typedef struct packed {
        logic        read;
        logic        write;
        logic [31:0] address;
        logic [31:0] writedata;
        logic [3:0]  byte_enable;
    } avalon_req_t;

    typedef struct packed {
        logic [31:0] readdata;
        logic        waitrequest;
    } avalon_resp_t;

    typedef enum logic [1:0] {
        ARB_IDLE  = 2'd0,
        ARB_LOCK0 = 2'd1,
        ARB_LOCK1 = 2'd2
    } arb_state_t;

endpackage

module cache_mem_arbiter
    import cache_mem_arbiter_pkg::*;
#(
    parameter bit RR_EN = 1'b1
) (
    input  logic         clk,
    input  logic         rst,
    input  avalon_req_t  p0_avn_req,
    output avalon_resp_t p0_avn_resp,
    input  avalon_req_t  p1_avn_req,
    output avalon_resp_t p1_avn_resp,
    output avalon_req_t  mem_avn_req,
    input  avalon_resp_t mem_avn_resp,
    output arb_state_t   fsm_state
);

    arb_state_t state;
    arb_state_t state_next;
    logic       last_grant;
    logic       last_grant_next;
    logic       req0;
    logic       req1;
    logic       grant_vld;
    logic       grant_sel;
    logic       accept;

    assign fsm_state = state;

    // State register and last-granted pointer; port 1 after reset so port 0 wins the first tie.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= ARB_IDLE;
            last_grant <= 1'b1;
        end else begin
            state      <= state_next;
            last_grant <= last_grant_next;
        end
    end

    // Grant selection, next-state logic and the merged bus / per-port responses.
    always_comb begin
        req0            = p0_avn_req.read | p0_avn_req.write;
        req1            = p1_avn_req.read | p1_avn_req.write;
        grant_vld       = 1'b0;
        grant_sel       = 1'b0;
        state_next      = state;
        last_grant_next = last_grant;

        // An owned bus only ever serves its owner; a dropped request frees it
        // without issuing a memory access.
        unique case (state)
            ARB_IDLE: begin
                if (req0 && req1) begin
                    grant_vld = 1'b1;
                    grant_sel = RR_EN ? ~last_grant : 1'b0;
                end else if (req0) begin
                    grant_vld = 1'b1;
                    grant_sel = 1'b0;
                end else if (req1) begin
                    grant_vld = 1'b1;
                    grant_sel = 1'b1;
                end
            end
            ARB_LOCK0: begin
                grant_vld = req0;
                grant_sel = 1'b0;
            end
            ARB_LOCK1: begin
                grant_vld = req1;
                grant_sel = 1'b1;
            end
            default: begin
                grant_vld = 1'b0;
                grant_sel = 1'b0;
            end
        endcase

        accept = grant_vld & ~mem_avn_resp.waitrequest;

        unique case (state)
            ARB_IDLE: begin
                if (grant_vld && mem_avn_resp.waitrequest)
                    state_next = grant_sel ? ARB_LOCK1 : ARB_LOCK0;
            end
            ARB_LOCK0, ARB_LOCK1: begin
                if (!grant_vld || accept)
                    state_next = ARB_IDLE;
            end
            default: state_next = ARB_IDLE;
        endcase

        if (accept)
            last_grant_next = grant_sel;

        // Forward the granted port as-is; with no grant the address lines idle on port 0.
        if (grant_vld && grant_sel)
            mem_avn_req = p1_avn_req;
        else
            mem_avn_req = p0_avn_req;
        if (!grant_vld || rst) begin
            mem_avn_req.read  = 1'b0;
            mem_avn_req.write = 1'b0;
        end

        // Read data is shared; each master only looks at it after its own read.
        p0_avn_resp.readdata = mem_avn_resp.readdata;
        p1_avn_resp.readdata = mem_avn_resp.readdata;

        if (rst)
            p0_avn_resp.waitrequest = 1'b0;
        else if (grant_vld && !grant_sel)
            p0_avn_resp.waitrequest = mem_avn_resp.waitrequest;
        else
            p0_avn_resp.waitrequest = req0;

        if (rst)
            p1_avn_resp.waitrequest = 1'b0;
        else if (grant_vld && grant_sel)
            p1_avn_resp.waitrequest = mem_avn_resp.waitrequest;
        else
            p1_avn_resp.waitrequest = req1;
    end

endmodule
